// File: rtl/fetch_sequencer.sv
// fetch_sequencer: instruction-fetch controller that owns the PC, drives a one-cycle-latency memory and hands PC-tagged words to decode
//
// Ports:
//   clk            system clock, rising edge
//   reset          asynchronous, active-high reset
//   o_mem_addr     byte address of the word being fetched (always the PC)
//   i_mem_instr    memory read data, valid the cycle after o_mem_addr was sampled
//   o_out_valid    o_out_instr/o_out_pc hold a fetched instruction
//   i_out_ready    decode accepts this cycle
//   o_out_instr    fetched instruction word
//   o_out_pc       byte address of o_out_instr
//   i_redir_valid  branch/jump redirect request
//   i_redir_pc     redirect target
//   i_halt_req     stop issuing new fetches while high
//   o_halted       fetch idle and drained
//   o_fault        sticky out-of-range (or misaligned) fetch indication
//
// Optional feature: define FETCH_ALIGN_CHECK_EN to make a misaligned redirect
// target raise the fault instead of being silently aligned down.
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned MEM_BYTES = 2048
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] o_mem_addr,
    input  logic [31:0] i_mem_instr,
    output logic        o_out_valid,
    input  logic        i_out_ready,
    output logic [31:0] o_out_instr,
    output logic [31:0] o_out_pc,
    input  logic        i_redir_valid,
    input  logic [31:0] i_redir_pc,
    input  logic        i_halt_req,
    output logic        o_halted,
    output logic        o_fault
);
    localparam logic [1:0]  S_RUN   = 2'd0;
    localparam logic [1:0]  S_HALT  = 2'd1;
    localparam logic [1:0]  S_FAULT = 2'd2;
    localparam logic [31:0] LAST_PC = 32'(MEM_BYTES - 4);

    logic [31:0] r_pc, r_inflight_pc, r_skid_instr, r_skid_pc;
    logic        r_inflight, r_skid_valid, r_fault;
    logic [1:0]  r_state;
    logic [31:0] w_redir_pc;
    logic        w_redir, w_misalign, w_has_word, w_range_bad;
    logic        w_issue_ok, w_issue, w_capture;

    // FAULT is terminal, so redirects are ignored there
    assign w_redir = i_redir_valid && r_state != S_FAULT;
`ifdef FETCH_ALIGN_CHECK_EN
    assign w_misalign = i_redir_pc[1:0] != 2'b00;
    assign w_redir_pc = i_redir_pc;
`else
    assign w_misalign = 1'b0;
    assign w_redir_pc = i_redir_pc & 32'hFFFF_FFFC;
`endif

    // inflight and skid are never both set: a capture always clears inflight
    // and nothing issues while the skid is full
    assign w_has_word  = r_skid_valid || r_inflight;
    assign w_range_bad = r_pc > LAST_PC;
    assign w_issue_ok  = r_state == S_RUN && !w_redir && !i_halt_req && !r_skid_valid
                         && (!r_inflight || i_out_ready);
    assign w_issue     = w_issue_ok && !w_range_bad;
    assign w_capture   = r_inflight && !r_skid_valid && !i_out_ready;

    assign o_mem_addr  = r_pc;
    assign o_out_valid = w_has_word && !w_redir;
    assign o_out_instr = r_skid_valid ? r_skid_instr : r_inflight ? i_mem_instr : 32'd0;
    assign o_out_pc    = r_skid_valid ? r_skid_pc : r_inflight ? r_inflight_pc : 32'd0;
    assign o_halted    = r_state == S_HALT || (r_state == S_FAULT && !w_has_word);
    assign o_fault     = r_fault;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc          <= RESET_PC;
            r_inflight_pc <= 32'd0;
            r_inflight    <= 1'b0;
            r_skid_valid  <= 1'b0;
            r_skid_instr  <= 32'd0;
            r_skid_pc     <= 32'd0;
            r_state       <= S_RUN;
            r_fault       <= 1'b0;
        end else if (w_redir) begin
            // a redirect flushes wrong-path words; halt resumes once drained
            r_inflight   <= 1'b0;
            r_skid_valid <= 1'b0;
            if (w_misalign) begin
                r_fault <= 1'b1;
                r_state <= S_FAULT;
            end else begin
                r_pc    <= w_redir_pc;
                r_state <= (r_state == S_HALT && i_halt_req) ? S_HALT : S_RUN;
            end
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                r_pc          <= r_pc + 32'd4;
                r_inflight_pc <= r_pc;
            end
            if (w_capture) begin
                r_skid_valid <= 1'b1;
                r_skid_instr <= i_mem_instr;
                r_skid_pc    <= r_inflight_pc;
            end else if (i_out_ready) begin
                r_skid_valid <= 1'b0;
            end
            if (w_issue_ok && w_range_bad) begin
                r_fault <= 1'b1;
                r_state <= S_FAULT;
            end else if (r_state == S_RUN && i_halt_req && !w_has_word) begin
                r_state <= S_HALT;
            end else if (r_state == S_HALT && !i_halt_req) begin
                r_state <= S_RUN;
            end
        end
    end
endmodule
